aes_shiftrows_stream: RTL and testbench

AES_SHIFTROWS_STREAM -- requirements
Module: aes_shiftrows_stream

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_shiftrows_stream_if.sv | 27 ++
 rtl/aes_shiftrows_perm.sv | 32 +++
 rtl/aes_shiftrows_stream.sv | 99 +++++++++
 tb/tb_aes_shiftrows_stream.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared Rijndael ShiftRows helpers: legal block widths, row offsets, byte positions.
package aes_pkg;

    // Legal Rijndael block widths in 32-bit columns.
    function automatic bit nb_legal(input int unsigned nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Row rotation amount: 0,1,2,3 for Nb=4/6; 0,1,3,4 for Nb=8.
    function automatic int unsigned shift_of(input int unsigned nb, input int unsigned row);
        if ((nb == 8) && (row >= 2)) begin
            return row + 1;
        end
        return row;
    endfunction

    // MSB bit index of state byte (row, col); byte 0 sits in the top bits (column-major).
    function automatic int unsigned byte_msb(input int unsigned state_w, input int unsigned row,
                                             input int unsigned col);
        return state_w - 1 - 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/aes_shiftrows_stream_if.sv
// Stream handshake bundle for the ShiftRows stage, plus flush and fill level.
interface aes_shiftrows_stream_if #(
    parameter int unsigned STATE_W = 128
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_data;
    logic               in_inv;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_data;
    logic               out_inv;
    logic [1:0]         level;

    // Driver / sink side.
    modport master (
        output flush, in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_inv, level
    );

    // Block side.
    modport slave (
        input  flush, in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_inv, level
    );
endinterface

// File: rtl/aes_shiftrows_perm.sv
// Combinational (Inv)ShiftRows byte permutation for an Nb-column Rijndael state.
module aes_shiftrows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] i_data,
    input  logic             i_inv,
    output logic [32*NB-1:0] o_data
);

    localparam int unsigned STATE_W = 32 * NB;

    if (!nb_legal(NB)) begin : gen_bad_nb
        $error("aes_shiftrows_perm: NB must be 4, 6 or 8");
    end

    // Each output byte picks one input byte from the same row; direction chosen by i_inv.
    for (genvar r = 0; r < 4; r++) begin : gen_row
        localparam int unsigned SHIFT = shift_of(NB, r);
        for (genvar c = 0; c < NB; c++) begin : gen_col
            localparam int unsigned SRC_FWD = (c + SHIFT) % NB;
            localparam int unsigned SRC_INV = (c + NB - SHIFT) % NB;
            localparam int unsigned DST_MSB = byte_msb(STATE_W, r, c);
            localparam int unsigned FWD_MSB = byte_msb(STATE_W, r, SRC_FWD);
            localparam int unsigned INV_MSB = byte_msb(STATE_W, r, SRC_INV);

            assign o_data[DST_MSB -: 8] = i_inv ? i_data[INV_MSB -: 8] : i_data[FWD_MSB -: 8];
        end
    end

endmodule

// File: rtl/aes_shiftrows_stream.sv
// ShiftRows / InvShiftRows stream stage: permute at push, hold results in a 2-entry FIFO.
module aes_shiftrows_stream
    import aes_pkg::*;
#(
    parameter int unsigned NB      = 4,
    parameter int unsigned STATE_W = 32 * NB
) (
    input logic                   clk,
    input logic                   rst_n,
    aes_shiftrows_stream_if.slave bus
);

    if (STATE_W != 32 * NB) begin : gen_bad_width
        $error("aes_shiftrows_stream: STATE_W must equal 32*NB");
    end

    logic [STATE_W-1:0] w_perm;

    logic [STATE_W-1:0] r_data [2];
    logic [1:0]         r_inv;
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_level;
    logic               r_in_ready;

    logic               w_push;
    logic               w_pop;
    logic               w_wptr_nxt;
    logic               w_rptr_nxt;
    logic [1:0]         w_level_nxt;

    aes_shiftrows_perm #(
        .NB (NB)
    ) u_perm (
        .i_data (bus.in_data),
        .i_inv  (bus.in_inv),
        .o_data (w_perm)
    );

    // Next-state for pointers and level; flush wins over any push/pop in the same cycle.
    always_comb begin
        w_push      = bus.in_valid & r_in_ready;
        w_pop       = (r_level != 2'd0) & bus.out_ready;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_level_nxt = r_level;
        if (bus.flush) begin
            w_wptr_nxt  = 1'b0;
            w_rptr_nxt  = 1'b0;
            w_level_nxt = 2'd0;
        end else begin
            if (w_push) begin
                w_wptr_nxt = ~r_wptr;
            end
            if (w_pop) begin
                w_rptr_nxt = ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + 2'd1;
                2'b01:   w_level_nxt = r_level - 2'd1;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // Control state; in_ready is registered so it stays low in reset and has no out_ready path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_level    <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_level    <= w_level_nxt;
            r_in_ready <= (w_level_nxt != 2'd2);
        end
    end

    // Entry storage: permuted state plus its direction tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_inv     <= '0;
        end else if (w_push && !bus.flush) begin
            r_data[r_wptr] <= w_perm;
            r_inv[r_wptr]  <= bus.in_inv;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_level != 2'd0);
    assign bus.out_data  = r_data[r_rptr];
    assign bus.out_inv   = r_inv[r_rptr];
    assign bus.level     = r_level;

endmodule

// File: tb/tb_aes_shiftrows_stream.sv
// Directed bench for aes_shiftrows_stream at NB=4 and NB=8.
module tb_aes_shiftrows_stream;

    localparam logic [127:0] V_A_IN     = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V_A_OUT    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V_SEQ4     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V_SEQ4_FWD = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] V_SEQ4_INV = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [255:0] V_SEQ8     =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] V_SEQ8_FWD =
        256'h00050e13040912170_80d161b0c111a1f10151e03141902071_81d060b1c010a0f;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    aes_shiftrows_stream_if #(.STATE_W(128)) bus_a ();
    aes_shiftrows_stream_if #(.STATE_W(256)) bus_b ();

    aes_shiftrows_stream #(
        .NB (4)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    aes_shiftrows_stream #(
        .NB (8)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [127:0] d, input logic inv);
        bus_a.in_valid = v;
        bus_a.in_data  = d;
        bus_a.in_inv   = inv;
    endtask

    logic [127:0] alt_in  [4];
    logic [127:0] alt_exp [4];
    logic         alt_inv [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        alt_in[0] = V_A_IN;   alt_exp[0] = V_A_OUT;    alt_inv[0] = 1'b0;
        alt_in[1] = V_A_OUT;  alt_exp[1] = V_A_IN;     alt_inv[1] = 1'b1;
        alt_in[2] = V_SEQ4;   alt_exp[2] = V_SEQ4_FWD; alt_inv[2] = 1'b0;
        alt_in[3] = V_SEQ4;   alt_exp[3] = V_SEQ4_INV; alt_inv[3] = 1'b1;

        rst_n           = 1'b0;
        bus_a.flush     = 1'b0;
        bus_a.out_ready = 1'b1;
        drive_a(1'b0, '0, 1'b0);
        bus_b.flush     = 1'b0;
        bus_b.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = '0;
        bus_b.in_inv    = 1'b0;

        // Reset state
        #12;
        check_eq("rst_level", bus_a.level, 2'd0);
        check_eq("rst_out_valid", bus_a.out_valid, 1'b0);
        check_eq("rst_in_ready", bus_a.in_ready, 1'b0);
        check_eq("rst_out_data", bus_a.out_data, '0);
        check_eq("rst_out_inv", bus_a.out_inv, 1'b0);
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_before_edge", bus_a.in_ready, 1'b0);
        step();
        check_eq("in_ready_after_edge", bus_a.in_ready, 1'b1);
        check_eq("b_in_ready_after_edge", bus_b.in_ready, 1'b1);

        // Single forward beat at level 0 with out_ready high: no bypass, one cycle latency
        drive_a(1'b1, V_A_IN, 1'b0);
        check_eq("no_bypass", bus_a.out_valid, 1'b0);
        step();
        drive_a(1'b0, '0, 1'b0);
        check_eq("fwd_valid", bus_a.out_valid, 1'b1);
        check_eq("fwd_data", bus_a.out_data, V_A_OUT);
        check_eq("fwd_inv", bus_a.out_inv, 1'b0);
        check_eq("fwd_level", bus_a.level, 2'd1);
        step();
        check_eq("fwd_drained", bus_a.level, 2'd0);

        // Back-to-back alternating fwd/inv beats at one per cycle
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, alt_in[i], alt_inv[i]);
            step();
            check_eq($sformatf("alt%0d_data", i), bus_a.out_data, alt_exp[i]);
            check_eq($sformatf("alt%0d_inv", i), bus_a.out_inv, alt_inv[i]);
            check_eq($sformatf("alt%0d_level", i), bus_a.level, 2'd1);
            check_eq($sformatf("alt%0d_in_ready", i), bus_a.in_ready, 1'b1);
        end
        drive_a(1'b0, '0, 1'b0);
        step();
        check_eq("alt_drained", bus_a.out_valid, 1'b0);

        // NB=8: forward then inverse of the result
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = V_SEQ8;
        bus_b.in_inv   = 1'b0;
        step();
        check_eq("nb8_fwd_data", bus_b.out_data, V_SEQ8_FWD);
        check_eq("nb8_fwd_inv", bus_b.out_inv, 1'b0);
        bus_b.in_data = V_SEQ8_FWD;
        bus_b.in_inv  = 1'b1;
        step();
        bus_b.in_valid = 1'b0;
        check_eq("nb8_inv_data", bus_b.out_data, V_SEQ8);
        check_eq("nb8_inv_inv", bus_b.out_inv, 1'b1);
        step();
        check_eq("nb8_drained", bus_b.level, 2'd0);

        // Stall: out_ready low for 4 cycles with 3 beats offered
        bus_a.out_ready = 1'b0;
        drive_a(1'b1, alt_in[0], alt_inv[0]);
        step();
        check_eq("stall_l1", bus_a.level, 2'd1);
        drive_a(1'b1, alt_in[1], alt_inv[1]);
        step();
        check_eq("stall_l2", bus_a.level, 2'd2);
        check_eq("stall_in_ready", bus_a.in_ready, 1'b0);
        drive_a(1'b1, alt_in[2], alt_inv[2]);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq($sformatf("stall_hold%0d_level", i), bus_a.level, 2'd2);
            check_eq($sformatf("stall_hold%0d_data", i), bus_a.out_data, alt_exp[0]);
            check_eq($sformatf("stall_hold%0d_inv", i), bus_a.out_inv, alt_inv[0]);
        end
        bus_a.out_ready = 1'b1;
        step();
        check_eq("rel1_data", bus_a.out_data, alt_exp[1]);
        check_eq("rel1_inv", bus_a.out_inv, alt_inv[1]);
        check_eq("rel1_level", bus_a.level, 2'd1);
        step();
        drive_a(1'b0, '0, 1'b0);
        check_eq("rel2_data", bus_a.out_data, alt_exp[2]);
        check_eq("rel2_level", bus_a.level, 2'd1);
        step();
        check_eq("rel_drained", bus_a.out_valid, 1'b0);

        // Flush at level 1 with a beat offered in the same cycle
        bus_a.out_ready = 1'b0;
        drive_a(1'b1, alt_in[0], alt_inv[0]);
        step();
        check_eq("flush_pre_level", bus_a.level, 2'd1);
        bus_a.flush     = 1'b1;
        bus_a.out_ready = 1'b1;
        drive_a(1'b1, alt_in[1], alt_inv[1]);
        step();
        bus_a.flush = 1'b0;
        drive_a(1'b0, '0, 1'b0);
        check_eq("flush_level", bus_a.level, 2'd0);
        check_eq("flush_out_valid", bus_a.out_valid, 1'b0);
        step();
        check_eq("flush_not_stored", bus_a.level, 2'd0);

        // Asynchronous reset with level 2
        bus_a.out_ready = 1'b0;
        drive_a(1'b1, alt_in[2], alt_inv[2]);
        step();
        drive_a(1'b1, alt_in[3], alt_inv[3]);
        step();
        drive_a(1'b0, '0, 1'b0);
        check_eq("arst_pre_level", bus_a.level, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_level", bus_a.level, 2'd0);
        check_eq("arst_out_valid", bus_a.out_valid, 1'b0);
        check_eq("arst_in_ready", bus_a.in_ready, 1'b0);
        check_eq("arst_out_data", bus_a.out_data, '0);
        #1;
        rst_n = 1'b1;
        step();
        check_eq("arst_rel_in_ready", bus_a.in_ready, 1'b1);
        check_eq("arst_rel_level", bus_a.level, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
